// File: rtl/ev_plc_cmd_sequencer.sv
// PLC command sequencer: steps a motor controller through opcode phases and
// time-multiplexes accel/brake. Optional readback check: EV_SEQ_READBACK_EN.
module ev_plc_cmd_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int SLOT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_power,
    input  logic       req_headlight,
    input  logic       req_horn,
    input  logic       req_right_ind,
    input  logic [3:0] req_accel,
    input  logic [3:0] req_brake,
    output logic [2:0] op_sel,
    output logic       power_on,
    output logic       headlight,
    output logic       horn,
    output logic       right_ind,
    output logic [3:0] ab_data,
    output logic       ab_phase,
    input  logic       power_status,
    input  logic       overheat_warning,
    input  logic [7:0] motor_speed_in,
    output logic       busy,
    output logic       seq_done,
    output logic       fault_skip,
    output logic       speed_err
);
    localparam int SPD_CYCLES = 2 * SLOT_CYCLES;
    localparam int MAXC       = (SPD_CYCLES > HOLD_CYCLES) ? SPD_CYCLES : HOLD_CYCLES;
    localparam int CW         = $clog2(MAXC);
    localparam int SW         = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_POWER, S_HEAD, S_HORN, S_IND, S_SPEED, S_PWM, S_OFF, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, len_m1;
    logic            pwr_q, head_q, horn_q, ind_q, fault_q;
    logic [3:0]      accel_q, brake_q;
    logic [SW-1:0]   slot_q;
    logic            phase_q;
    logic            accept, last;

    assign accept = req_valid && (state_q == S_IDLE);
    assign len_m1 = (state_q == S_SPEED) ? CW'(SPD_CYCLES - 1) : CW'(HOLD_CYCLES - 1);
    assign last   = (cnt_q == len_m1);

    always_comb begin
        state_d = state_q;
        op_sel  = 3'b110;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_POWER;
            S_POWER: begin op_sel = 3'b000; if (last) state_d = pwr_q ? S_HEAD : S_OFF; end
            S_HEAD:  begin op_sel = 3'b001; if (last) state_d = S_HORN; end
            S_HORN:  begin op_sel = 3'b010; if (last) state_d = S_IND; end
            // Overheat seen at the end of IND aborts straight to DONE.
            S_IND:   begin op_sel = 3'b011; if (last) state_d = overheat_warning ? S_DONE : S_SPEED; end
            S_SPEED: begin op_sel = 3'b100; if (last) state_d = S_PWM; end
            S_PWM:   begin op_sel = 3'b101; if (last) state_d = S_DONE; end
            S_OFF:   begin op_sel = 3'b111; if (last) state_d = S_DONE; end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_q == S_IDLE || state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pwr_q   <= 1'b0;
            head_q  <= 1'b0;
            horn_q  <= 1'b0;
            ind_q   <= 1'b0;
            accel_q <= '0;
            brake_q <= '0;
            fault_q <= 1'b0;
            slot_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pwr_q   <= req_power;
                head_q  <= req_headlight;
                horn_q  <= req_horn;
                ind_q   <= req_right_ind;
                accel_q <= req_accel;
                brake_q <= req_brake;
                fault_q <= 1'b0;
            end else if (state_q == S_IND && last && overheat_warning) begin
                fault_q <= 1'b1;
            end
            if (slot_q == SW'(SLOT_CYCLES - 1)) begin
                slot_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                slot_q  <= slot_q + SW'(1);
            end
        end
    end

`ifdef EV_SEQ_READBACK_EN
    logic       err_q;
    logic [7:0] exp_speed;
    logic       unused_rb;

    assign exp_speed = (accel_q > brake_q) ? {accel_q - brake_q, 4'b0000} : 8'h00;
    assign unused_rb = power_status;

    // Only a completed power-on run (no overheat skip) is checked.
    always_ff @(posedge clk) begin
        if (rst || accept)
            err_q <= 1'b0;
        else if (state_q == S_DONE && pwr_q && !fault_q && motor_speed_in != exp_speed)
            err_q <= 1'b1;
    end
    assign speed_err = err_q;
`else
    logic unused_rb;
    assign unused_rb = ^{power_status, motor_speed_in};
    assign speed_err = 1'b0;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign seq_done   = (state_q == S_DONE);
    assign fault_skip = fault_q;
    assign power_on   = pwr_q;
    assign headlight  = head_q;
    assign horn       = horn_q;
    assign right_ind  = ind_q;
    assign ab_phase   = phase_q;
    assign ab_data    = phase_q ? brake_q : accel_q;
endmodule

// File: doc/ev_plc_cmd_sequencer.md
EV_PLC_CMD_SEQUENCER -- requirements
Module: ev_plc_cmd_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles each opcode is held on op_sel (minimum 2).
REQ-002 SHALL have parameter SLOT_CYCLES, default 16: cycles per accel/brake nibble slot.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: command request present.
REQ-006 SHALL have port req_ready, output, 1: sequencer accepts a request this cycle.
REQ-007 SHALL have ports req_power, req_headlight, req_horn, req_right_ind, input, 1 each: requested control states.
REQ-008 SHALL have ports req_accel, req_brake, input, 4 each: requested accelerator and brake values.
REQ-009 SHALL have port op_sel, output, 3: opcode to motor controller.
REQ-010 SHALL have ports power_on, headlight, horn, right_ind, output, 1 each: latched control lines to the controller.
REQ-011 SHALL have port ab_data, output, 4: time-multiplexed accel/brake nibble.
REQ-012 SHALL have port ab_phase, output, 1: 0 = accel slot, 1 = brake slot.
REQ-013 SHALL have ports power_status, overheat_warning, input, 1 each; motor_speed_in, input, 8: controller readback.
REQ-014 SHALL have ports busy, seq_done, fault_skip, speed_err, output, 1 each.

Function
REQ-015 SHALL accept a request when req_valid && req_ready; req_ready = 1 only in IDLE; req_valid while busy ignored, not queued.
REQ-016 SHALL latch all req_* fields on acceptance and drive the latched control values on power_on/headlight/horn/right_ind until the next acceptance.
REQ-017 SHALL implement states IDLE, POWER(000), HEAD(001), HORN(010), IND(011), SPEED(100), PWM(101), OFF(111), DONE.
REQ-018 SHALL drive op_sel = 3'b110 (no-op) in IDLE and DONE, else the state's opcode.
REQ-019 SHALL enter POWER the cycle after acceptance; each opcode state lasts HOLD_CYCLES cycles, except SPEED, which lasts 2*SLOT_CYCLES.
REQ-020 SHALL, with latched power = 1, sequence POWER, HEAD, HORN, IND, SPEED, PWM, DONE.
REQ-021 SHALL, with latched power = 0, sequence POWER, OFF, DONE.
REQ-022 SHALL sample overheat_warning on the last cycle of IND; if 1, go to DONE (skip SPEED/PWM) and set fault_skip, cleared on next acceptance.
REQ-023 SHALL spend exactly 1 cycle in DONE, pulse seq_done for that cycle, then return to IDLE.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL run a free-running slot counter 0..SLOT_CYCLES-1, independent of the FSM, toggling ab_phase on wrap from SLOT_CYCLES-1 to 0.
REQ-026 SHALL drive ab_data = latched accel when ab_phase = 0, latched brake when ab_phase = 1, updating the cycle ab_phase changes.

Reset
REQ-027 SHALL on rst force IDLE, op_sel = 110, all control outputs, ab_data, ab_phase, slot counter, busy, seq_done, fault_skip, speed_err = 0, latched fields = 0.
REQ-028 SHALL treat rst mid-sequence identically: IDLE and req_ready = 1 the cycle after rst deasserts, with no seq_done.

Configuration
REQ-029 SHALL, when macro EV_SEQ_READBACK_EN is defined, in DONE of a full power-on sequence compare motor_speed_in with expected = {accel-brake, 4'b0000} (expected = 0 if brake >= accel) and set speed_err on mismatch, sticky until next acceptance.
REQ-030 SHALL, without EV_SEQ_READBACK_EN, tie speed_err to 0 and exclude comparison logic; power_status and motor_speed_in unused.

Verification
REQ-031 SHALL cover: rst high 2 cycles -> op_sel = 110, all outputs 0, req_ready = 1, ab_phase toggles every 16 cycles after release.
REQ-032 SHALL cover: accept at T with power=1, headlight=1, horn=0, right_ind=1, accel=9, brake=3 -> op_sel 000 T+1..T+4, 001 T+5..T+8, 010 T+9..T+12, 011 T+13..T+16, 100 T+17..T+48, 101 T+49..T+52, seq_done at T+53; ab_data alternates 9/3.
REQ-033 SHALL cover: accept with power=0 at T -> op_sel 000 T+1..T+4, 111 T+5..T+8, seq_done at T+9.
REQ-034 SHALL cover: overheat_warning=1 at T+16 of a power-on sequence -> DONE at T+17, fault_skip = 1, op_sel never 100.
REQ-035 SHALL cover: with EV_SEQ_READBACK_EN, accel=9, brake=3, motor_speed_in=0x60 -> speed_err = 0; 0x50 -> speed_err = 1; macro undefined -> speed_err = 0.
REQ-036 SHALL cover: rst pulsed during SPEED, and req_valid held during busy -> IDLE next cycle with op_sel = 110; held request accepted only once IDLE.
